trigger_unit: RTL and testbench

TRIGGER_UNIT -- requirements
Module: trigger_unit

---
 rtl/trigger_unit_pkg.sv | 8 +
 rtl/trigger_qualifier.sv | 23 ++
 rtl/trigger_unit.sv | 78 +++++++
 tb/tb_trigger_unit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/trigger_unit_pkg.sv
// trigger_unit_pkg: shared state encoding, edge-mode constants and default parameters
package trigger_unit_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RECORDING, S_DONE} state_t;
  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE = 1'b1;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/trigger_qualifier.sv
// trigger_qualifier: registers previous trigger lines (reset to ones) and produces the masked level/edge-qualified vector
module trigger_qualifier
  import trigger_unit_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] trig,
  input  logic [NUM_CH-1:0] mask,
  input  logic              edge_mode,
  output logic [NUM_CH-1:0] qual
);
  logic [NUM_CH-1:0] prev_q, prev_d;
  always_comb begin
    prev_d = trig;
    qual = mask & ((edge_mode == MODE_EDGE) ? (trig & ~prev_q) : trig);
  end
  always_ff @(posedge clk) begin
    if (rst) prev_q <= '1;
    else prev_q <= prev_d;
  end
endmodule

// File: rtl/trigger_unit.sv
// trigger_unit: arm/trigger/record/done sequencer with post-trigger counter and sticky trigger source
module trigger_unit
  import trigger_unit_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Armed,
  input  logic [NUM_CH-1:0] Trigger,
  input  logic [NUM_CH-1:0] ChannelMask,
  input  logic              EdgeMode,
  input  logic [CNT_W-1:0]  PostCount,
  input  logic              Rearm,
  output logic              EnableRecordingOut,
  output logic [NUM_CH-1:0] TriggerSource,
  output logic              Done
);
  logic [NUM_CH-1:0] qual;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0] src_q, src_d;
  logic en_q, en_d, done_q, done_d;
  trigger_qualifier #(.NUM_CH(NUM_CH)) u_qual (
    .clk(Clock),
    .rst(Reset),
    .trig(Trigger),
    .mask(ChannelMask),
    .edge_mode(EdgeMode),
    .qual(qual)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    src_d = src_q;
    case (state_q)
      S_IDLE: state_d = Armed ? S_ARMED : S_IDLE;
      S_ARMED:
        if (!Armed) state_d = S_IDLE;
        else if (|qual) begin
          state_d = S_RECORDING;
          cnt_d = PostCount;
          src_d = qual;
        end
      S_RECORDING:
        if (Rearm) begin
          state_d = S_IDLE;
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          cnt_d = '0;
        end else if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      S_DONE: state_d = Rearm ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
    en_d = state_d == S_RECORDING;
    done_d = state_d == S_DONE;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      src_q <= '0;
      en_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      src_q <= src_d;
      en_q <= en_d;
      done_q <= done_d;
    end
  end
  assign EnableRecordingOut = en_q;
  assign TriggerSource = src_q;
  assign Done = done_q;
endmodule

// File: tb/tb_trigger_unit.sv
// tb_trigger_unit: randomized and directed checks of trigger_unit against a behavioural model
module tb_trigger_unit;
  logic clk = 1'b0;
  logic Reset, Armed, EdgeMode, Rearm;
  logic [3:0] Trigger, ChannelMask;
  logic [15:0] PostCount;
  logic EnableRecordingOut, Done;
  logic [3:0] TriggerSource;
  int n_cmp = 0;
  int n_bad = 0;
  int ph = 0;
  int len = 0;
  int el = 0;
  logic [3:0] m_src = '0;
  logic [3:0] m_prev = '1;
  logic seen;
  always #5 clk = ~clk;
  trigger_unit dut (
    .Clock(clk),
    .Reset(Reset),
    .Armed(Armed),
    .Trigger(Trigger),
    .ChannelMask(ChannelMask),
    .EdgeMode(EdgeMode),
    .PostCount(PostCount),
    .Rearm(Rearm),
    .EnableRecordingOut(EnableRecordingOut),
    .TriggerSource(TriggerSource),
    .Done(Done)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  task automatic model_step();
    logic [3:0] q;
    q = ChannelMask & (EdgeMode ? (Trigger & ~m_prev) : Trigger);
    m_prev = Reset ? 4'hf : Trigger;
    if (Reset) begin
      ph = 0; m_src = '0; len = 0; el = 0;
    end else if (ph == 0) ph = Armed ? 1 : 0;
    else if (ph == 1) begin
      if (!Armed) ph = 0;
      else if (q != 0) begin
        ph = 2; m_src = q; len = int'(PostCount); el = 0;
      end
    end else if (ph == 2) begin
      if (Rearm) ph = 0;
      else if (len != 0 && el + 1 == len) ph = 3;
      else el++;
    end else if (Rearm) ph = 0;
  endtask
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("en", 32'(EnableRecordingOut), 32'(ph == 2));
    chk("done", 32'(Done), 32'(ph == 3));
    chk("src", 32'(TriggerSource), 32'(m_src));
  endtask
  task automatic rst_pulse();
    Reset = 1'b1; cyc(); Reset = 1'b0;
  endtask
  initial begin
    Reset = 1'b1; Armed = 1'b0; EdgeMode = 1'b0; Rearm = 1'b0;
    Trigger = '0; ChannelMask = '0; PostCount = '0;
    @(negedge clk);
    cyc(); cyc();
    chk("rst_en", 32'(EnableRecordingOut), 32'd0);
    chk("rst_src", 32'(TriggerSource), 32'd0);
    Reset = 1'b0;
    // level mode, mask 0010, PostCount 5
    ChannelMask = 4'b0010; PostCount = 16'd5; Armed = 1'b1;
    repeat (3) cyc();
    Trigger = 4'b0010; cyc(); Trigger = '0;
    for (int i = 0; i < 5; i++) begin
      chk("l5_en", 32'(EnableRecordingOut), 32'd1);
      cyc();
    end
    chk("l5_en_off", 32'(EnableRecordingOut), 32'd0);
    chk("l5_done", 32'(Done), 32'd1);
    chk("l5_src", 32'(TriggerSource), 32'h2);
    // edge mode, line held high through reset release
    EdgeMode = 1'b1; ChannelMask = 4'b0001; Trigger = 4'b0001; Armed = 1'b0;
    rst_pulse();
    Armed = 1'b1;
    repeat (5) cyc();
    chk("edge_none", 32'(EnableRecordingOut), 32'd0);
    Trigger = '0; cyc();
    Trigger = 4'b0001; cyc();
    chk("edge_fire", 32'(EnableRecordingOut), 32'd1);
    // PostCount 0 records until Rearm
    EdgeMode = 1'b0; Trigger = '0; PostCount = '0;
    rst_pulse();
    cyc();
    Trigger = 4'b0001; cyc(); Trigger = '0;
    PostCount = 16'd3;
    repeat (1000) cyc();
    chk("inf_en", 32'(EnableRecordingOut), 32'd1);
    Rearm = 1'b1; cyc(); Rearm = 1'b0;
    chk("inf_rearm", 32'(EnableRecordingOut), 32'd0);
    // Armed drop with trigger in the same cycle
    cyc();
    Armed = 1'b0; Trigger = 4'b0001; cyc(); Trigger = '0;
    chk("drop_en", 32'(EnableRecordingOut), 32'd0);
    Armed = 1'b1; cyc();
    // mask zero never triggers
    ChannelMask = '0; seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      Trigger = 4'($urandom); cyc(); seen |= EnableRecordingOut;
    end
    chk("mask0", 32'(seen), 32'd0);
    // Reset mid recording, then a full 8-cycle recording
    ChannelMask = 4'b1111; Trigger = '0; PostCount = 16'd8;
    rst_pulse(); cyc();
    Trigger = 4'b0100; cyc(); Trigger = '0;
    cyc(); cyc();
    rst_pulse();
    chk("mid_en", 32'(EnableRecordingOut), 32'd0);
    chk("mid_src", 32'(TriggerSource), 32'd0);
    cyc();
    Trigger = 4'b1000; cyc(); Trigger = '0;
    for (int i = 0; i < 8; i++) begin
      chk("r8_en", 32'(EnableRecordingOut), 32'd1);
      cyc();
    end
    chk("r8_done", 32'(Done), 32'd1);
    // Rearm coinciding with expiry
    Rearm = 1'b1; cyc(); Rearm = 1'b0;
    PostCount = 16'd3; cyc();
    Trigger = 4'b0001; cyc(); Trigger = '0;
    cyc(); cyc();
    Rearm = 1'b1; cyc(); Rearm = 1'b0;
    chk("rx_en", 32'(EnableRecordingOut), 32'd0);
    chk("rx_done", 32'(Done), 32'd0);
    cyc();
    chk("rx_done2", 32'(Done), 32'd0);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      Reset = ($urandom % 300) == 0;
      Armed = ($urandom % 20) != 0;
      Rearm = ($urandom % 30) == 0;
      Trigger = 4'($urandom) & 4'($urandom) & 4'($urandom);
      if ($urandom % 50 == 0) ChannelMask = 4'($urandom);
      if ($urandom % 50 == 0) EdgeMode = 1'($urandom);
      PostCount = ($urandom % 8 == 0) ? 16'd0 : 16'($urandom_range(1, 12));
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
